// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB over a unified memory port,
// with memory watchdog, illegal-opcode fault and optional PERF_COUNTER_EN counters.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 7,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                pc_write,
    output logic                ir_write,
    output logic                branch,
    output logic                memRead,
    output logic                memWrite,
    output logic                memtoReg,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                ALUSrc,
    output logic                regWrite,
    output logic                instr_retired,
    output logic                fault,
    output logic [1:0]          fault_code
`ifdef PERF_COUNTER_EN
    ,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    instr_count
`endif
);

    // A disabled watchdog still keeps a 1-bit counter so no zero-width vector appears.
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_BR  = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(7'b0010011);

    localparam int N_LEGAL = 6;
    localparam logic [OPCODE_W-1:0] LEGAL_OPS [N_LEGAL] = '{OP_LW, OP_SW, OP_R, OP_BR, OP_JAL, OP_I};

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] ALU_IMM   = ALUOP_W'(2'b11);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [WAIT_W-1:0]    wait_cnt_reg;
    logic [OPCODE_W-1:0]  opcode_q_reg;
    logic                 fault_reg;
    logic [1:0]           fault_code_reg;
    logic [1:0]           fault_code_next;
    logic [N_LEGAL-1:0]   legal_hit;
    logic                 opcode_legal;
    logic                 timeout_hit;

    generate
        for (genvar gi = 0; gi < N_LEGAL; gi++) begin : g_legal
            assign legal_hit[gi] = (opcode == LEGAL_OPS[gi]);
        end
    endgenerate

    assign opcode_legal = |legal_hit;

    // The watchdog fires only when the final allowed wait cycle also sees no ready.
    generate
        if (MEM_TIMEOUT != 0) begin : g_watchdog
            assign timeout_hit = (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;
        end else begin : g_no_watchdog
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_FETCH;
            wait_cnt_reg   <= '0;
            opcode_q_reg   <= '0;
            fault_reg      <= 1'b0;
            fault_code_reg <= FC_NONE;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
            end else if ((state_reg == S_FETCH || state_reg == S_MEM) && !mem_ready) begin
                wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end
            if (state_reg == S_DECODE) begin
                opcode_q_reg <= opcode;
            end
            if (state_next == S_FAULT && state_reg != S_FAULT) begin
                fault_reg      <= 1'b1;
                fault_code_reg <= fault_code_next;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        fault_code_next = fault_code_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next      = S_FAULT;
                    fault_code_next = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (opcode_legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next      = S_FAULT;
                    fault_code_next = FC_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (opcode_q_reg)
                    OP_LW, OP_SW:      state_next = S_MEM;
                    OP_R, OP_I, OP_JAL: state_next = S_WB;
                    OP_BR:             state_next = S_FETCH;
                    default: begin
                        state_next      = S_FAULT;
                        fault_code_next = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = (opcode_q_reg == OP_LW) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_next      = S_FAULT;
                    fault_code_next = FC_TIMEOUT;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FETCH;
        endcase
    end

    // Reset gates every output so an aborted instruction never leaks a write.
    always_comb begin
        mem_req       = 1'b0;
        iord          = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        branch        = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        memtoReg      = 1'b0;
        ALUOp         = ALU_ADD;
        ALUSrc        = 1'b0;
        regWrite      = 1'b0;
        instr_retired = 1'b0;
        fault         = 1'b0;
        fault_code    = FC_NONE;
        if (!reset) begin
            fault      = fault_reg;
            fault_code = fault_code_reg;
            case (state_reg)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        ALUOp    = ALU_ADD;
                        ALUSrc   = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opcode_q_reg)
                        OP_LW, OP_SW: begin
                            ALUSrc = 1'b1;
                            ALUOp  = ALU_ADD;
                        end
                        OP_R: ALUOp = ALU_FUNCT;
                        OP_I: begin
                            ALUSrc = 1'b1;
                            ALUOp  = ALU_IMM;
                        end
                        OP_BR: begin
                            branch        = 1'b1;
                            ALUOp         = ALU_SUB;
                            instr_retired = 1'b1;
                        end
                        OP_JAL: begin
                            pc_write = 1'b1;
                            ALUOp    = ALU_ADD;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req       = 1'b1;
                    iord          = 1'b1;
                    memRead       = (opcode_q_reg == OP_LW);
                    memWrite      = (opcode_q_reg == OP_SW);
                    instr_retired = mem_ready && (opcode_q_reg == OP_SW);
                end
                S_WB: begin
                    regWrite      = 1'b1;
                    memtoReg      = (opcode_q_reg == OP_LW);
                    instr_retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_COUNTER_EN
    logic [CNT_W-1:0] cycle_count_reg;
    logic [CNT_W-1:0] instr_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
        end else if (!fault_reg) begin
            cycle_count_reg <= cycle_count_reg + CNT_W'(1);
            if (instr_retired) begin
                instr_count_reg <= instr_count_reg + CNT_W'(1);
            end
        end
    end

    assign cycle_count = cycle_count_reg;
    assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: each step drives one clock cycle and
// checks the packed control vector against a hand-computed value.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, pc_write, ir_write, branch, memRead, memWrite, memtoReg;
    logic [1:0] ALUOp;
    logic       ALUSrc, regWrite, instr_retired, fault;
    logic [1:0] fault_code;
`ifdef PERF_COUNTER_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BAD = 7'b1111111;

    // Bit order: mem_req iord pc_write ir_write branch memRead memWrite memtoReg
    //            ALUOp[1:0] ALUSrc regWrite instr_retired fault fault_code[1:0]
    localparam logic [15:0] V_IDLE    = 16'h0000;
    localparam logic [15:0] V_F_WAIT  = 16'h8000;
    localparam logic [15:0] V_F_RDY   = 16'hB020;
    localparam logic [15:0] V_E_R     = 16'h0080;
    localparam logic [15:0] V_E_I     = 16'h00E0;
    localparam logic [15:0] V_E_MEM   = 16'h0020;
    localparam logic [15:0] V_E_BR    = 16'h0848;
    localparam logic [15:0] V_E_JAL   = 16'h2000;
    localparam logic [15:0] V_M_LW    = 16'hC400;
    localparam logic [15:0] V_M_SW_W  = 16'hC200;
    localparam logic [15:0] V_M_SW_R  = 16'hC208;
    localparam logic [15:0] V_WB      = 16'h0018;
    localparam logic [15:0] V_WB_LW   = 16'h0118;
    localparam logic [15:0] V_F_ILL   = 16'h0005;
    localparam logic [15:0] V_F_TO    = 16'h0006;

    logic [15:0] obs;
    assign obs = {mem_req, iord, pc_write, ir_write, branch, memRead, memWrite, memtoReg,
                  ALUOp, ALUSrc, regWrite, instr_retired, fault, fault_code};

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .iord         (iord),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .branch       (branch),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memtoReg     (memtoReg),
        .ALUOp        (ALUOp),
        .ALUSrc       (ALUSrc),
        .regWrite     (regWrite),
        .instr_retired(instr_retired),
        .fault        (fault),
        .fault_code   (fault_code)
`ifdef PERF_COUNTER_EN
        ,
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
`endif
    );

    // One clock cycle: drive this cycle's inputs just after the edge, then check outputs.
    task automatic cyc(input logic rst, input logic [6:0] op, input logic rdy,
                       input logic [15:0] exp, input string tag);
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        #1;
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("step %-12s ctrl=%h", tag, obs);
    endtask

`ifdef PERF_COUNTER_EN
    task automatic perf_chk(input logic [31:0] ec, input logic [31:0] ei, input string tag);
        total++;
        assert (cycle_count === ec) else begin
            bad++;
            $error("FAIL %s_cycles observed=%0d expected=%0d", tag, cycle_count, ec);
        end
        total++;
        assert (instr_count === ei) else begin
            bad++;
            $error("FAIL %s_instrs observed=%0d expected=%0d", tag, instr_count, ei);
        end
        $display("perf %-12s cycles=%0d instrs=%0d", tag, cycle_count, instr_count);
    endtask
`endif

    initial begin
        cyc(1, 7'd0, 0, V_IDLE, "rst0");
        cyc(1, RT,   1, V_IDLE, "rst1");

        // R-type, zero wait; opcode changes after DECODE must not matter
        cyc(0, 7'd0, 1, V_F_RDY, "r_fetch");
        cyc(0, RT,   1, V_IDLE,  "r_decode");
        cyc(0, 7'd0, 1, V_E_R,   "r_exec");
        cyc(0, BAD,  1, V_WB,    "r_wb");

        // LW, 2 waits in FETCH and 3 in MEM: retires in the 10th cycle
        cyc(0, 7'd0, 0, V_F_WAIT, "lw_fwait1");
        cyc(0, 7'd0, 0, V_F_WAIT, "lw_fwait2");
        cyc(0, 7'd0, 1, V_F_RDY,  "lw_fetch");
        cyc(0, LW,   1, V_IDLE,   "lw_decode");
        cyc(0, 7'd0, 1, V_E_MEM,  "lw_exec");
        cyc(0, 7'd0, 0, V_M_LW,   "lw_mwait1");
        cyc(0, 7'd0, 0, V_M_LW,   "lw_mwait2");
        cyc(0, 7'd0, 0, V_M_LW,   "lw_mwait3");
        cyc(0, 7'd0, 1, V_M_LW,   "lw_mem");
        cyc(0, 7'd0, 1, V_WB_LW,  "lw_wb");

        // SW then BEQ, zero wait: 4 + 3 cycles
        cyc(0, 7'd0, 1, V_F_RDY,  "sw_fetch");
        cyc(0, SW,   1, V_IDLE,   "sw_decode");
        cyc(0, 7'd0, 1, V_E_MEM,  "sw_exec");
        cyc(0, 7'd0, 1, V_M_SW_R, "sw_mem");
        cyc(0, 7'd0, 1, V_F_RDY,  "br_fetch");
        cyc(0, BR,   1, V_IDLE,   "br_decode");
        cyc(0, 7'd0, 1, V_E_BR,   "br_exec");

        // I-type and JAL
        cyc(0, 7'd0, 1, V_F_RDY,  "i_fetch");
        cyc(0, IT,   1, V_IDLE,   "i_decode");
        cyc(0, 7'd0, 1, V_E_I,    "i_exec");
        cyc(0, 7'd0, 1, V_WB,     "i_wb");
        cyc(0, 7'd0, 1, V_F_RDY,  "jal_fetch");
        cyc(0, JAL,  1, V_IDLE,   "jal_decode");
        cyc(0, 7'd0, 1, V_E_JAL,  "jal_exec");
        cyc(0, 7'd0, 1, V_WB,     "jal_wb");

        // SW with one MEM wait, then ready arriving in the last allowed FETCH wait cycle
        cyc(0, 7'd0, 1, V_F_RDY,  "sw2_fetch");
        cyc(0, SW,   1, V_IDLE,   "sw2_decode");
        cyc(0, 7'd0, 1, V_E_MEM,  "sw2_exec");
        cyc(0, 7'd0, 0, V_M_SW_W, "sw2_mwait");
        cyc(0, 7'd0, 1, V_M_SW_R, "sw2_mem");
        for (int i = 0; i < 4; i++) cyc(0, 7'd0, 0, V_F_WAIT, "edge_fwait");
        cyc(0, 7'd0, 1, V_F_RDY,  "edge_fetch5");
        cyc(0, RT,   1, V_IDLE,   "edge_decode");
        cyc(0, 7'd0, 1, V_E_R,    "edge_exec");
        cyc(0, 7'd0, 1, V_WB,     "edge_wb");

        // Reset pulsed while an LW waits in MEM, then a full FETCH timeout
        cyc(0, 7'd0, 1, V_F_RDY,  "lw2_fetch");
        cyc(0, LW,   1, V_IDLE,   "lw2_decode");
        cyc(0, 7'd0, 1, V_E_MEM,  "lw2_exec");
        cyc(0, 7'd0, 0, V_M_LW,   "lw2_mwait");
        cyc(1, 7'd0, 1, V_IDLE,   "rst_in_mem");
        cyc(0, 7'd0, 0, V_F_WAIT, "post_rst");
`ifdef PERF_COUNTER_EN
        perf_chk(32'd0, 32'd0, "post_rst");
`endif
        for (int i = 0; i < 4; i++) cyc(0, 7'd0, 0, V_F_WAIT, "to_fwait");
        cyc(0, 7'd0, 0, V_F_TO, "to_fault");
        for (int i = 0; i < 3; i++) cyc(0, RT, 1, V_F_TO, "to_hold");

        // Illegal opcode: sticky fault, no memory request for 20 cycles
        cyc(1, 7'd0, 1, V_IDLE,   "rst2");
        cyc(0, 7'd0, 1, V_F_RDY,  "ill_fetch");
        cyc(0, BAD,  1, V_IDLE,   "ill_decode");
        for (int i = 0; i < 20; i++) cyc(0, RT, 1, V_F_ILL, "ill_hold");
`ifdef PERF_COUNTER_EN
        perf_chk(32'd2, 32'd0, "fault_frozen");
`endif

        // Three R-type instructions at zero wait
        cyc(1, 7'd0, 1, V_IDLE, "rst3");
        for (int n = 0; n < 3; n++) begin
            cyc(0, 7'd0, 1, V_F_RDY, "r3_fetch");
            cyc(0, RT,   1, V_IDLE,  "r3_decode");
            cyc(0, 7'd0, 1, V_E_R,   "r3_exec");
            cyc(0, 7'd0, 1, V_WB,    "r3_wb");
        end
        cyc(0, 7'd0, 1, V_F_RDY, "r3_next");
`ifdef PERF_COUNTER_EN
        perf_chk(32'd12, 32'd3, "three_r");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
